jacobi_sweep_scheduler: RTL and testbench

Sequences the cyclic-by-row Jacobi sweep order for the eigenvalue engine. On a start command it emits every off-diagonal index pair (p,q), p<q, of an N×N symmetric matrix, once per sweep, for a programmable number of sweeps. Each pair is presented on a valid/ready handshake together with the precomputed row-major BRAM addresses of elements (p,p), (p,q) and (q,q). The consumer is the main controller, which uses each pair to drive the angle pipeline and the rotation CORDIC.

---
 rtl/jacobi_sweep_scheduler_pkg.sv | 43 ++++
 rtl/jacobi_sweep_scheduler.sv | 147 ++++++++++++++
 tb/tb_jacobi_sweep_scheduler.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/jacobi_sweep_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jacobi_sweep_scheduler_pkg
// Purpose  : Shared types, constants and address helper for the Jacobi
//            eigenvalue engine sweep scheduler and its consumers.
// Contents : JACOBI_N / JACOBI_IDX_W / JACOBI_ADDR_WIDTH constants,
//            scheduler state enum, pair struct, jacobi_addr() helper.
// Revision : 1.0 - initial release
// ============================================================================
package jacobi_sweep_scheduler_pkg;

  localparam int JACOBI_N          = 8;
  localparam int JACOBI_IDX_W      = $clog2(JACOBI_N);
  localparam int JACOBI_ADDR_WIDTH = $clog2(JACOBI_N * JACOBI_N);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } jacobi_state_e;

  // One rotation pair plus the row-major addresses of its three elements,
  // sized for the default engine dimension.
  typedef struct packed {
    logic [JACOBI_IDX_W-1:0]      p;
    logic [JACOBI_IDX_W-1:0]      q;
    logic [JACOBI_ADDR_WIDTH-1:0] addr_pp;
    logic [JACOBI_ADDR_WIDTH-1:0] addr_pq;
    logic [JACOBI_ADDR_WIDTH-1:0] addr_qq;
  } jacobi_pair_t;

  // Row-major address of element (row, col). n is a constant at every call
  // site, so this reduces to a multiply-by-constant plus add.
  function automatic logic [31:0] jacobi_addr(
    input logic [31:0] row,
    input logic [31:0] col,
    input logic [31:0] n = 32'(JACOBI_N)
  );
    return row * n + col;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jacobi_sweep_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : jacobi_sweep_scheduler
// Purpose  : Emits the cyclic-by-row Jacobi pair order (p<q) of an NxN
//            symmetric matrix for a programmable number of sweeps, with the
//            BRAM addresses of (p,p), (p,q), (q,q) on a valid/ready handshake.
// Ports    : clk, rst (async, active-high)
//            start_i, num_sweeps_i, abort_i        - run control
//            pair_p_o, pair_q_o, addr_*_o          - pair payload
//            pair_vld_o / pair_rdy_i               - handshake
//            last_in_sweep_o, sweep_idx_o          - position in the run
//            busy_o, done_o                        - status
// Revision : 1.0 - initial release
// ============================================================================
module jacobi_sweep_scheduler
  import jacobi_sweep_scheduler_pkg::*;
#(
  parameter int N           = JACOBI_N,
  parameter int ADDR_WIDTH  = JACOBI_ADDR_WIDTH,
  parameter int SWEEP_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [SWEEP_WIDTH-1:0] num_sweeps_i,
  input  logic                   abort_i,
  output logic [$clog2(N)-1:0]   pair_p_o,
  output logic [$clog2(N)-1:0]   pair_q_o,
  output logic [ADDR_WIDTH-1:0]  addr_pp_o,
  output logic [ADDR_WIDTH-1:0]  addr_pq_o,
  output logic [ADDR_WIDTH-1:0]  addr_qq_o,
  output logic                   pair_vld_o,
  input  logic                   pair_rdy_i,
  output logic                   last_in_sweep_o,
  output logic [SWEEP_WIDTH-1:0] sweep_idx_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] C_LAST_P = IDX_W'(N - 2);
  localparam logic [IDX_W-1:0] C_LAST_Q = IDX_W'(N - 1);

  jacobi_state_e          state_q, state_d;
  logic [IDX_W-1:0]       p_q, p_d, q_q, q_d;
  logic [SWEEP_WIDTH-1:0] sweep_q, sweep_d, count_q, count_d;
  logic [ADDR_WIDTH-1:0]  pp_q, pp_d, pq_q, pq_d, qq_q, qq_d;
  logic                   last_q, last_d;

  // Next-state: pair advance, sweep counting, run control.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    q_d     = q_q;
    sweep_d = sweep_q;
    count_d = count_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          p_d     = '0;
          q_d     = IDX_W'(1);
          sweep_d = '0;
          count_d = num_sweeps_i;
          state_d = (num_sweeps_i != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (pair_rdy_i) begin
          if (q_q != C_LAST_Q) begin
            q_d = q_q + IDX_W'(1);
          end else if (p_q != C_LAST_P) begin
            // New row starts just right of the new diagonal element.
            p_d = p_q + IDX_W'(1);
            q_d = p_q + IDX_W'(2);
          end else begin
            p_d = '0;
            q_d = IDX_W'(1);
            if (sweep_q == count_q - SWEEP_WIDTH'(1)) begin
              state_d = ST_DONE;
            end else begin
              sweep_d = sweep_q + SWEEP_WIDTH'(1);
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything and leaves the pair counters at the
    // start-of-sweep position so a later start looks like a fresh one.
    if (abort_i) begin
      state_d = ST_IDLE;
      p_d     = '0;
      q_d     = IDX_W'(1);
      sweep_d = '0;
    end
  end

  // Addresses and the last flag follow the next-state pair so they land in
  // their registers on the same edge as p/q.
  always_comb begin
    pp_d   = ADDR_WIDTH'(jacobi_addr(32'(p_d), 32'(p_d), 32'(N)));
    pq_d   = ADDR_WIDTH'(jacobi_addr(32'(p_d), 32'(q_d), 32'(N)));
    qq_d   = ADDR_WIDTH'(jacobi_addr(32'(q_d), 32'(q_d), 32'(N)));
    last_d = (p_d == C_LAST_P) && (q_d == C_LAST_Q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      p_q     <= '0;
      q_q     <= IDX_W'(1);
      sweep_q <= '0;
      count_q <= '0;
      pp_q    <= '0;
      pq_q    <= '0;
      qq_q    <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      sweep_q <= sweep_d;
      count_q <= count_d;
      pp_q    <= pp_d;
      pq_q    <= pq_d;
      qq_q    <= qq_d;
      last_q  <= last_d;
    end
  end

  assign pair_p_o        = p_q;
  assign pair_q_o        = q_q;
  assign addr_pp_o       = pp_q;
  assign addr_pq_o       = pq_q;
  assign addr_qq_o       = qq_q;
  assign sweep_idx_o     = sweep_q;
  // last is only meaningful alongside a valid pair.
  assign last_in_sweep_o = last_q && (state_q == ST_RUN);
  assign pair_vld_o      = (state_q == ST_RUN);
  assign busy_o          = (state_q == ST_RUN);
  assign done_o          = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_jacobi_sweep_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_jacobi_sweep_scheduler
// Purpose  : Self-checking bench for jacobi_sweep_scheduler with an N=4 and
//            an N=8 instance. Stimulus pushes expected pairs into per-DUT
//            queues; negedge monitors compare every presented pair.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jacobi_sweep_scheduler;

  typedef struct {
    int p; int q; int pp; int pq; int qq; int last; int sweep;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ---------------- N=4 instance ----------------
  logic       start4, abort4, rdy4;
  logic [3:0] num4;
  logic [1:0] p4, q4;
  logic [3:0] pp4, pq4, qq4, sw4;
  logic       vld4, last4, busy4, done4;

  jacobi_sweep_scheduler #(.N(4), .ADDR_WIDTH(4), .SWEEP_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start_i(start4), .num_sweeps_i(num4),
    .abort_i(abort4), .pair_p_o(p4), .pair_q_o(q4), .addr_pp_o(pp4),
    .addr_pq_o(pq4), .addr_qq_o(qq4), .pair_vld_o(vld4), .pair_rdy_i(rdy4),
    .last_in_sweep_o(last4), .sweep_idx_o(sw4), .busy_o(busy4), .done_o(done4)
  );

  // ---------------- N=8 instance ----------------
  logic       start8, abort8, rdy8;
  logic [3:0] num8;
  logic [2:0] p8, q8;
  logic [5:0] pp8, pq8, qq8;
  logic [3:0] sw8;
  logic       vld8, last8, busy8, done8;

  jacobi_sweep_scheduler #(.N(8), .ADDR_WIDTH(6), .SWEEP_WIDTH(4)) dut8 (
    .clk(clk), .rst(rst), .start_i(start8), .num_sweeps_i(num8),
    .abort_i(abort8), .pair_p_o(p8), .pair_q_o(q8), .addr_pp_o(pp8),
    .addr_pq_o(pq8), .addr_qq_o(qq8), .pair_vld_o(vld8), .pair_rdy_i(rdy8),
    .last_in_sweep_o(last8), .sweep_idx_o(sw8), .busy_o(busy8), .done_o(done8)
  );

  exp_t sb4[$];
  exp_t sb8[$];
  int   hs8 = 0;

  // Hand-computed N=4 sweep: {p, q, pp, pq, qq}
  int t4 [6][5] = '{'{0,1,0,1,5}, '{0,2,0,2,10}, '{0,3,0,3,15},
                    '{1,2,5,6,10}, '{1,3,5,7,15}, '{2,3,10,11,15}};

  task automatic chk(input string nm, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic chk_pair(input string nm, input exp_t e, input int p, input int q,
                          input int pp, input int pq, input int qq, input int l,
                          input int s);
    tests++;
    if (p != e.p || q != e.q || pp != e.pp || pq != e.pq || qq != e.qq ||
        l != e.last || s != e.sweep) begin
      fails++;
      $display("FAIL %s: got p=%0d q=%0d pp=%0d pq=%0d qq=%0d last=%0d sw=%0d, expected p=%0d q=%0d pp=%0d pq=%0d qq=%0d last=%0d sw=%0d (t=%0t)",
               nm, p, q, pp, pq, qq, l, s, e.p, e.q, e.pp, e.pq, e.qq, e.last, e.sweep, $time);
    end
  endtask

  task automatic push4(input int sweep, input int count);
    exp_t e;
    for (int i = 0; i < count; i++) begin
      e.p = t4[i][0]; e.q = t4[i][1]; e.pp = t4[i][2]; e.pq = t4[i][3];
      e.qq = t4[i][4]; e.last = (i == 5) ? 1 : 0; e.sweep = sweep;
      sb4.push_back(e);
    end
  endtask

  task automatic push8(input int sweeps);
    exp_t e;
    for (int s = 0; s < sweeps; s++)
      for (int p = 0; p < 7; p++)
        for (int q = p + 1; q < 8; q++) begin
          e.p = p; e.q = q; e.pp = p * 9; e.pq = p * 8 + q; e.qq = q * 9;
          e.last = (p == 6 && q == 7) ? 1 : 0; e.sweep = s;
          sb8.push_back(e);
        end
  endtask

  // Monitors: every cycle a pair is valid it must match the queue head;
  // the head is retired only on a handshake, so stalls re-check it.
  always @(negedge clk) begin
    if (rst !== 1'b1 && vld4 === 1'b1) begin
      if (sb4.size() == 0) chk("pair4_unexpected_vld", 1, 0);
      else begin
        chk_pair("pair4", sb4[0], int'(p4), int'(q4), int'(pp4), int'(pq4),
                 int'(qq4), int'(last4), int'(sw4));
        if (rdy4) void'(sb4.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst !== 1'b1 && vld8 === 1'b1) begin
      if (sb8.size() == 0) chk("pair8_unexpected_vld", 1, 0);
      else begin
        chk_pair("pair8", sb8[0], int'(p8), int'(q8), int'(pp8), int'(pq8),
                 int'(qq8), int'(last8), int'(sw8));
        if (rdy8) begin
          void'(sb8.pop_front());
          hs8++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit sel8, input int maxc, output int cyc);
    cyc = 0;
    repeat (maxc) begin
      tick();
      cyc++;
      if ((sel8 ? done8 : done4) === 1'b1) return;
    end
    cyc = -1;
  endtask

  int cyc;
  int hs_base;
  int seen;

  initial begin
    rst = 1'b1;
    start4 = 0; abort4 = 0; rdy4 = 0; num4 = '0;
    start8 = 0; abort8 = 0; rdy8 = 0; num8 = '0;
    #2;
    // Reset state
    chk("rst_vld4", int'(vld4), 0);
    chk("rst_busy4", int'(busy4), 0);
    chk("rst_done4", int'(done4), 0);
    chk("rst_q4", int'(q4), 1);
    chk("rst_vld8", int'(vld8), 0);
    chk("rst_sweep8", int'(sw8), 0);
    chk("rst_pq8", int'(pq8), 0);
    tick(); tick();
    rst = 1'b0;

    // N=4, one sweep, ready held high
    push4(0, 6);
    start4 = 1; num4 = 4'd1; rdy4 = 1;
    tick();
    start4 = 0;
    wait_done(1'b0, 50, cyc);
    chk("n4_done_latency", cyc, 6);
    chk("n4_busy_at_done", int'(busy4), 0);
    chk("n4_vld_at_done", int'(vld4), 0);
    chk("n4_queue_drained", sb4.size(), 0);
    tick();
    chk("n4_done_one_cycle", int'(done4), 0);

    // N=8, three sweeps, random ready, ignored start mid-run
    push8(3);
    hs_base = hs8;
    start8 = 1; num8 = 4'd3;
    tick();
    start8 = 0;
    cyc = -1;
    for (int c = 1; c <= 3000; c++) begin
      rdy8 = 1'($urandom_range(0, 1));
      if (c == 20) begin start8 = 1; num8 = 4'd1; end
      else start8 = 0;
      tick();
      if (done8 === 1'b1) begin cyc = c; break; end
    end
    start8 = 0; rdy8 = 0;
    chk("n8_done_seen", int'(cyc > 0), 1);
    chk("n8_handshakes", hs8 - hs_base, 84);
    chk("n8_queue_drained", sb8.size(), 0);
    chk("n8_busy_at_done", int'(busy8), 0);
    tick();

    // Zero-sweep start
    start8 = 1; num8 = 4'd0;
    tick();
    start8 = 0;
    chk("zero_done", int'(done8), 1);
    chk("zero_vld", int'(vld8), 0);
    chk("zero_busy", int'(busy8), 0);
    tick();
    chk("zero_done_clear", int'(done8), 0);

    // Abort at the 5th pair with ready low
    push4(0, 5);
    start4 = 1; num4 = 4'd2; rdy4 = 1;
    tick();
    start4 = 0;
    repeat (4) tick();
    rdy4 = 0;
    tick();
    abort4 = 1;
    tick();
    abort4 = 0;
    chk("abort_vld", int'(vld4), 0);
    chk("abort_busy", int'(busy4), 0);
    chk("abort_done", int'(done4), 0);
    chk("abort_pending_pair", sb4.size(), 1);
    seen = 0;
    repeat (3) begin
      tick();
      if (done4 === 1'b1 || vld4 === 1'b1) seen++;
    end
    chk("abort_stays_idle", seen, 0);
    sb4.delete();
    push4(0, 6);
    start4 = 1; num4 = 4'd1; rdy4 = 1;
    tick();
    start4 = 0;
    wait_done(1'b0, 50, cyc);
    chk("restart_done_latency", cyc, 6);
    rdy4 = 0;
    tick();

    // Asynchronous reset mid-sweep
    push8(1);
    start8 = 1; num8 = 4'd1; rdy8 = 1;
    tick();
    start8 = 0;
    repeat (10) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_vld", int'(vld8), 0);
    chk("arst_busy", int'(busy8), 0);
    chk("arst_p", int'(p8), 0);
    chk("arst_q", int'(q8), 1);
    chk("arst_pp", int'(pp8), 0);
    chk("arst_pq", int'(pq8), 0);
    chk("arst_qq", int'(qq8), 0);
    chk("arst_last", int'(last8), 0);
    chk("arst_sweep", int'(sw8), 0);
    sb8.delete();
    tick(); tick();
    #2;
    rst = 1'b0;
    tick();
    push8(1);
    start8 = 1; num8 = 4'd1; rdy8 = 1;
    tick();
    start8 = 0;
    wait_done(1'b1, 100, cyc);
    chk("post_rst_done_latency", cyc, 28);
    chk("post_rst_queue_drained", sb8.size(), 0);
    rdy8 = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
